dprambe_sc: RTL and testbench

- Single-clock true dual-port RAM with byte enables. Next generation of the team's byte-enable dual-port RAM.
- Adds the following over that block:
  - configurable byte width and depth;
  - hardware clear sequence after reset;
  - read-request/valid handshake with selectable read latency;
  - defined same-address write-collision resolution;
  - selectable read-during-write behaviour.
- Used as the shared buffer between datapath engines and CSR/DMA masters in the same clock domain.

---
 rtl/dprambe_sc.sv | 198 +++++++++++++++++++
 tb/tb_dprambe_sc.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dprambe_sc.sv
// rtl/dprambe_sc.sv - single-clock true dual-port byte-enable RAM with clear sequence and read handshake
// Optional per-lane even parity storage and checking: define DPRAMBE_SC_PARITY_EN.
module dprambe_sc #(
    parameter int                DWIDTH         = 32,
    parameter int                BYTEW          = 8,
    parameter int                BEWIDTH        = DWIDTH / BYTEW,
    parameter int                AWIDTH         = 10,
    parameter int                DEPTH          = 1 << AWIDTH,
    parameter int                RDLAT          = 1,
    parameter string             RDW_MODE       = "OLD",
    parameter string             PRIORITY       = "A",
    parameter string             CLEAR_ON_RESET = "Y",
    parameter logic [DWIDTH-1:0] CLR_VALUE      = '0,
    parameter string             INIT_FILE      = ""
) (
    input  logic               clk,
    input  logic               rst,
    output logic               init_busy,
    input  logic               wea,
    input  logic               rea,
    input  logic [AWIDTH-1:0]  addra,
    input  logic [DWIDTH-1:0]  dataa,
    input  logic [BEWIDTH-1:0] bea,
    output logic [DWIDTH-1:0]  qa,
    output logic               qa_valid,
    output logic               qa_perr,
    input  logic               web,
    input  logic               reb,
    input  logic [AWIDTH-1:0]  addrb,
    input  logic [DWIDTH-1:0]  datab,
    input  logic [BEWIDTH-1:0] beb,
    output logic [DWIDTH-1:0]  qb,
    output logic               qb_valid,
    output logic               qb_perr,
    output logic               collision
);

    localparam bit                RDW_NEW = (RDW_MODE == "NEW");
    localparam bit                PRI_B   = (PRIORITY == "B");
    localparam bit                CLR_EN  = (CLEAR_ON_RESET == "Y");
    localparam logic [AWIDTH:0]   DEPTH_W = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH-1:0] LAST    = AWIDTH'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;
    localparam state_t RST_STATE = CLR_EN ? CLEAR : READY;

    function automatic logic [DWIDTH-1:0] merge(input logic [DWIDTH-1:0] old_w,
                                                input logic [DWIDTH-1:0] new_w,
                                                input logic [BEWIDTH-1:0] be);
        merge = old_w;
        for (int i = 0; i < BEWIDTH; i++)
            if (be[i]) merge[i*BYTEW +: BYTEW] = new_w[i*BYTEW +: BYTEW];
    endfunction

    logic [DWIDTH-1:0] mem [DEPTH];
    state_t            state, state_nx;
    logic [AWIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_STATE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == CLEAR) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        if (state == CLEAR && cnt == LAST) state_nx = READY;
    end

    assign init_busy = (state == CLEAR);

    logic ina, inb, wa, wb, ra, rb;
    assign ina = ({1'b0, addra} < DEPTH_W);
    assign inb = ({1'b0, addrb} < DEPTH_W);
    assign wa  = wea & ~init_busy & ina;
    assign wb  = web & ~init_busy & inb;
    assign ra  = rea & ~init_busy;
    assign rb  = reb & ~init_busy;

    // The high-priority port is applied on top of the low-priority merge so shared lanes take its data.
    logic                w_lo, w_hi;
    logic [AWIDTH-1:0]   a_lo, a_hi;
    logic [DWIDTH-1:0]   d_lo, d_hi, nw_lo, nw_hi;
    logic [BEWIDTH-1:0]  b_lo, b_hi;
    assign w_lo  = PRI_B ? wa : wb;
    assign a_lo  = PRI_B ? addra : addrb;
    assign d_lo  = PRI_B ? dataa : datab;
    assign b_lo  = PRI_B ? bea : beb;
    assign w_hi  = PRI_B ? wb : wa;
    assign a_hi  = PRI_B ? addrb : addra;
    assign d_hi  = PRI_B ? datab : dataa;
    assign b_hi  = PRI_B ? beb : bea;
    assign nw_lo = merge(mem[a_lo], d_lo, b_lo);
    assign nw_hi = merge((w_lo && a_lo == a_hi) ? nw_lo : mem[a_hi], d_hi, b_hi);

    always_ff @(posedge clk) begin
        if (init_busy) begin
            if (!rst) mem[cnt] <= CLR_VALUE;
        end else begin
            if (w_lo) mem[a_lo] <= nw_lo;
            if (w_hi) mem[a_hi] <= nw_hi;
        end
    end

    logic [DWIDTH-1:0] rda, rdb;
    always_comb begin
        rda = '0;
        rdb = '0;
        if (ina) rda = mem[addra];
        if (inb) rdb = mem[addrb];
        if (RDW_NEW && wa) rda = merge(rda, dataa, bea);
        if (RDW_NEW && wb) rdb = merge(rdb, datab, beb);
    end

    logic perr_a, perr_b;
`ifdef DPRAMBE_SC_PARITY_EN
    function automatic logic [BEWIDTH-1:0] lane_par(input logic [DWIDTH-1:0] w);
        lane_par = '0;
        for (int i = 0; i < BEWIDTH; i++) lane_par[i] = ^w[i*BYTEW +: BYTEW];
    endfunction

    logic [BEWIDTH-1:0] par [DEPTH];
    logic [BEWIDTH-1:0] p_lo, p_hi;
    assign p_lo = (par[a_lo] & ~b_lo) | (lane_par(d_lo) & b_lo);
    assign p_hi = (((w_lo && a_lo == a_hi) ? p_lo : par[a_hi]) & ~b_hi) | (lane_par(d_hi) & b_hi);

    always_ff @(posedge clk) begin
        if (init_busy) begin
            if (!rst) par[cnt] <= lane_par(CLR_VALUE);
        end else begin
            if (w_lo) par[a_lo] <= p_lo;
            if (w_hi) par[a_hi] <= p_hi;
        end
    end

    assign perr_a = ina && (par[addra] != lane_par(mem[addra]));
    assign perr_b = inb && (par[addrb] != lane_par(mem[addrb]));
`else
    assign perr_a = 1'b0;
    assign perr_b = 1'b0;
`endif

    logic [DWIDTH-1:0] s_qa, s_qb;
    logic              s_va, s_vb, s_pa, s_pb;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_qa      <= '0;
            s_qb      <= '0;
            s_va      <= 1'b0;
            s_vb      <= 1'b0;
            s_pa      <= 1'b0;
            s_pb      <= 1'b0;
            collision <= 1'b0;
        end else begin
            s_va      <= ra;
            s_vb      <= rb;
            s_pa      <= ra & perr_a;
            s_pb      <= rb & perr_b;
            if (ra) s_qa <= rda;
            if (rb) s_qb <= rdb;
            collision <= wa & wb & (addra == addrb) & (|(bea & beb));
        end
    end

    generate
        if (RDLAT == 2) begin : g_lat2
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    qa       <= '0;
                    qb       <= '0;
                    qa_valid <= 1'b0;
                    qb_valid <= 1'b0;
                    qa_perr  <= 1'b0;
                    qb_perr  <= 1'b0;
                end else begin
                    qa_valid <= s_va;
                    qb_valid <= s_vb;
                    qa_perr  <= s_pa;
                    qb_perr  <= s_pb;
                    if (s_va) qa <= s_qa;
                    if (s_vb) qb <= s_qb;
                end
            end
        end else begin : g_lat1
            assign qa       = s_qa;
            assign qb       = s_qb;
            assign qa_valid = s_va;
            assign qb_valid = s_vb;
            assign qa_perr  = s_pa;
            assign qb_perr  = s_pb;
        end
    endgenerate

endmodule

// File: tb/tb_dprambe_sc.sv
// tb/tb_dprambe_sc.sv - self-checking bench for dprambe_sc against a behavioural memory model
module tb_dprambe_sc;

    logic        clk = 1'b0;
    logic        rst;
    logic        we   [2][2];
    logic        re   [2][2];
    logic [3:0]  addr [2][2];
    logic [31:0] dat  [2][2];
    logic [3:0]  be   [2][2];
    logic [31:0] q    [2][2];
    logic        qv   [2][2];
    logic        qp   [2][2];
    logic        busy [2];
    logic        coll [2];

    always #5 clk = ~clk;

    dprambe_sc #(.DWIDTH(32), .BYTEW(8), .AWIDTH(4), .DEPTH(16), .RDLAT(1), .RDW_MODE("OLD"),
                 .PRIORITY("A"), .CLEAR_ON_RESET("Y"), .CLR_VALUE(32'hA5A5A5A5)) u0 (
        .clk(clk), .rst(rst), .init_busy(busy[0]),
        .wea(we[0][0]), .rea(re[0][0]), .addra(addr[0][0]), .dataa(dat[0][0]), .bea(be[0][0]),
        .qa(q[0][0]), .qa_valid(qv[0][0]), .qa_perr(qp[0][0]),
        .web(we[0][1]), .reb(re[0][1]), .addrb(addr[0][1]), .datab(dat[0][1]), .beb(be[0][1]),
        .qb(q[0][1]), .qb_valid(qv[0][1]), .qb_perr(qp[0][1]), .collision(coll[0]));

    dprambe_sc #(.DWIDTH(32), .BYTEW(8), .AWIDTH(4), .DEPTH(12), .RDLAT(2), .RDW_MODE("NEW"),
                 .PRIORITY("B"), .CLEAR_ON_RESET("Y"), .CLR_VALUE(32'h0)) u1 (
        .clk(clk), .rst(rst), .init_busy(busy[1]),
        .wea(we[1][0]), .rea(re[1][0]), .addra(addr[1][0]), .dataa(dat[1][0]), .bea(be[1][0]),
        .qa(q[1][0]), .qa_valid(qv[1][0]), .qa_perr(qp[1][0]),
        .web(we[1][1]), .reb(re[1][1]), .addrb(addr[1][1]), .datab(dat[1][1]), .beb(be[1][1]),
        .qb(q[1][1]), .qb_valid(qv[1][1]), .qb_perr(qp[1][1]), .collision(coll[1]));

    int          LAT  [2] = '{1, 2};
    int          DEP  [2] = '{16, 12};
    logic        NEWM [2] = '{1'b0, 1'b1};
    logic        PRIB [2] = '{1'b0, 1'b1};
    logic [31:0] CLRV [2] = '{32'hA5A5A5A5, 32'h0};

    typedef struct {
        int          idx;
        int          due;
        logic [31:0] d;
        logic        p;
    } rd_t;

    rd_t         pend[$];
    logic [31:0] mm      [2][16];
    logic        perr_m  [2][16];
    logic [31:0] last_q  [2][2];
    logic        coll_exp[2];
    int          busy_left[2];
    int          cyc, total, bad;

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
        mrg = o;
        for (int i = 0; i < 4; i++) if (b[i]) mrg[8*i +: 8] = n[8*i +: 8];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int p, input logic w, input logic r, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] b);
        for (int k = 0; k < 2; k++) begin
            we[k][p] = w; re[k][p] = r; addr[k][p] = a; dat[k][p] = d; be[k][p] = b;
        end
    endtask

    task automatic idle();
        drv(0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        drv(1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    endtask

    task automatic check_outputs();
        logic        found, pexp;
        logic [31:0] dexp;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                found = 1'b0; pexp = 1'b0; dexp = 32'h0;
                for (int i = 0; i < pend.size(); i++) begin
                    if (pend[i].idx == 2*k+p && pend[i].due == cyc) begin
                        found = 1'b1; dexp = pend[i].d; pexp = pend[i].p;
                        pend.delete(i);
                        break;
                    end
                end
                if (found) last_q[k][p] = dexp;
                chk($sformatf("valid_u%0d_p%0d_c%0d", k, p, cyc), 32'(qv[k][p]), 32'(found));
                chk($sformatf("q_u%0d_p%0d_c%0d", k, p, cyc), q[k][p], last_q[k][p]);
                if (found) chk($sformatf("perr_u%0d_p%0d_c%0d", k, p, cyc), 32'(qp[k][p]), 32'(pexp));
            end
            chk($sformatf("collision_u%0d_c%0d", k, cyc), 32'(coll[k]), 32'(coll_exp[k]));
            chk($sformatf("init_busy_u%0d_c%0d", k, cyc), 32'(busy[k]), 32'(busy_left[k] > 0));
        end
    endtask

    task automatic step();
        rd_t         e;
        logic [31:0] rd;
        int          ord[2];
        int          w;
        for (int k = 0; k < 2; k++) begin
            coll_exp[k] = 1'b0;
            if (busy_left[k] == 0) begin
                for (int p = 0; p < 2; p++) begin
                    if (re[k][p]) begin
                        rd = 32'h0; e.p = 1'b0;
                        if (int'(addr[k][p]) < DEP[k]) begin
                            rd = mm[k][addr[k][p]];
                            e.p = perr_m[k][addr[k][p]];
                            if (NEWM[k] && we[k][p]) rd = mrg(rd, dat[k][p], be[k][p]);
                        end
                        e.idx = 2*k+p; e.due = cyc + LAT[k]; e.d = rd;
                        pend.push_back(e);
                    end
                end
                coll_exp[k] = we[k][0] && we[k][1] && addr[k][0] == addr[k][1] &&
                              int'(addr[k][0]) < DEP[k] && (be[k][0] & be[k][1]) != 4'h0;
                ord[0] = PRIB[k] ? 0 : 1;
                ord[1] = 1 - ord[0];
                for (int j = 0; j < 2; j++) begin
                    w = ord[j];
                    if (we[k][w] && int'(addr[k][w]) < DEP[k]) begin
                        mm[k][addr[k][w]] = mrg(mm[k][addr[k][w]], dat[k][w], be[k][w]);
                        if (be[k][w][0]) perr_m[k][addr[k][w]] = 1'b0;
                    end
                end
            end
        end
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) if (busy_left[k] > 0) busy_left[k]--;
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        pend.delete();
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                last_q[k][p] = 32'h0;
                chk($sformatf("rst_q_u%0d_p%0d", k, p), q[k][p], 32'h0);
                chk($sformatf("rst_valid_u%0d_p%0d", k, p), 32'(qv[k][p]), 32'h0);
                chk($sformatf("rst_perr_u%0d_p%0d", k, p), 32'(qp[k][p]), 32'h0);
            end
            chk($sformatf("rst_busy_u%0d", k), 32'(busy[k]), 32'h1);
            chk($sformatf("rst_coll_u%0d", k), 32'(coll[k]), 32'h0);
            coll_exp[k] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            busy_left[k] = DEP[k];
            for (int a = 0; a < 16; a++) begin mm[k][a] = CLRV[k]; perr_m[k][a] = 1'b0; end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] a0, a1;
        total = 0; bad = 0; cyc = 0;
        rst = 1'b0;
        idle();
        #2;
        do_reset();
        // requests during the clear must be ignored; reset half-way restarts the sequence
        for (int n = 0; n < 8; n++) begin
            drv(0, 1'b1, 1'b1, 4'(n), 32'hFFFFFFFF, 4'hF);
            drv(1, 1'b0, 1'b1, 4'(15 - n), 32'h0, 4'h0);
            step();
        end
        idle();
        do_reset();
        for (int n = 0; n < 16; n++) begin
            drv(0, 1'b0, 1'b1, 4'(n), 32'h0, 4'h0);
            step();
        end
        idle();
        for (int n = 0; n < 16; n++) begin
            drv(0, 1'b0, 1'b1, 4'(n), 32'h0, 4'h0);
            drv(1, 1'b0, 1'b1, 4'(15 - n), 32'h0, 4'h0);
            step();
        end
        idle(); step(); step();

        drv(0, 1'b1, 1'b0, 4'd3, 32'h0, 4'hF); step(); idle();
        drv(0, 1'b1, 1'b0, 4'd3, 32'h11223344, 4'b0101); step(); idle();
        drv(0, 1'b0, 1'b1, 4'd3, 32'h0, 4'h0); step(); idle();
        chk("be_lanes_lat1", q[0][0], 32'h00220044);
        step();
        chk("be_lanes_lat2", q[1][0], 32'h00220044);
        step();

        drv(0, 1'b1, 1'b0, 4'd5, 32'h0, 4'hF); step(); idle();
        drv(0, 1'b1, 1'b0, 4'd5, 32'hAAAAAAAA, 4'b0011);
        drv(1, 1'b1, 1'b0, 4'd5, 32'hBBBBBBBB, 4'b0110);
        step(); idle();
        chk("coll_pulse_prio_a", 32'(coll[0]), 32'h1);
        drv(0, 1'b0, 1'b1, 4'd5, 32'h0, 4'h0); step(); idle();
        chk("coll_word_prio_a", q[0][0], 32'h00BBAAAA);
        step();
        chk("coll_word_prio_b", q[1][0], 32'h00BBBBAA);
        drv(0, 1'b1, 1'b0, 4'd5, 32'hAAAAAAAA, 4'b0011);
        drv(1, 1'b1, 1'b0, 4'd5, 32'hBBBBBBBB, 4'b1100);
        step(); idle();
        chk("no_coll_disjoint", 32'(coll[0]), 32'h0);
        drv(1, 1'b0, 1'b1, 4'd5, 32'h0, 4'h0); step(); idle();
        chk("disjoint_word", q[0][1], 32'hBBBBAAAA);
        step();

        drv(0, 1'b1, 1'b0, 4'd7, 32'h1, 4'hF); step(); idle();
        drv(0, 1'b1, 1'b1, 4'd7, 32'h2, 4'hF);
        drv(1, 1'b0, 1'b1, 4'd7, 32'h0, 4'h0);
        step(); idle();
        chk("rdw_old_same_port", q[0][0], 32'h1);
        chk("rdw_cross_port_lat1", q[0][1], 32'h1);
        step();
        chk("rdw_new_same_port", q[1][0], 32'h2);
        chk("rdw_cross_port_lat2", q[1][1], 32'h1);

        drv(0, 1'b1, 1'b0, 4'd13, 32'hDEADBEEF, 4'hF); step(); idle();
        drv(0, 1'b0, 1'b1, 4'd13, 32'h0, 4'h0); step(); idle(); step();
        chk("oor_read_data", q[1][0], 32'h0);
        chk("oor_read_valid", 32'(qv[1][0]), 32'h1);

`ifdef DPRAMBE_SC_PARITY_EN
        drv(0, 1'b1, 1'b0, 4'd4, 32'hFF00FF00, 4'hF); step(); idle();
        u0.mem[4][0] = ~u0.mem[4][0];
        u1.mem[4][0] = ~u1.mem[4][0];
        for (int k = 0; k < 2; k++) begin mm[k][4][0] = ~mm[k][4][0]; perr_m[k][4] = 1'b1; end
        drv(0, 1'b0, 1'b1, 4'd4, 32'h0, 4'h0);
        drv(1, 1'b0, 1'b1, 4'd2, 32'h0, 4'h0);
        step(); idle();
        chk("parity_err_flag", 32'(qp[0][0]), 32'h1);
        chk("parity_clean_flag", 32'(qp[0][1]), 32'h0);
        step();
        drv(0, 1'b1, 1'b0, 4'd4, 32'hFF00FF00, 4'hF); step(); idle();
`endif

        for (int n = 0; n < 400; n++) begin
            a0 = 4'($urandom_range(0, 15));
            a1 = ($urandom_range(0, 1) == 1) ? a0 : 4'($urandom_range(0, 15));
            drv(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a0, $urandom, 4'($urandom));
            drv(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a1, $urandom, 4'($urandom));
            step();
        end
        idle();
        step(); step(); step();
        chk("pending_drained", 32'(pend.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
